// File: rtl/mem_stage_lsu_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu_pkg
//   Shared definitions for the MEM pipeline stage:
//     - mem_mode_e   : funct3 encodings of the load/store access size
//     - lsu_state_e  : data-memory handshake FSM states
//     - ex_ctrl_t    : control bundle held in the EX/MEM register
//     - word_addr()  : word-aligned bus address from a byte address
// -----------------------------------------------------------------------------
package mem_stage_lsu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    MODE_B  = 3'b000,
    MODE_H  = 3'b001,
    MODE_W  = 3'b010,
    MODE_BU = 3'b100,
    MODE_HU = 3'b101
  } mem_mode_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } lsu_state_e;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       lui;
    logic       jump;
    logic [2:0] mode;
  } ex_ctrl_t;

  function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu_align
//   Purely combinational byte/halfword alignment for the MEM stage.
//   Ports:
//     i_is_load, i_is_store : kind of access being aligned
//     i_mode                : funct3 access mode (B/H/W/BU/HU)
//     i_addr_lo             : byte offset inside the word
//     i_store_data          : rs2 value of a store
//     i_rdata               : raw word returned by data memory
//     o_be, o_wdata         : byte enables and lane-replicated store data
//     o_load_data           : lane-selected, sign/zero-extended load value
//     o_fault               : misaligned address or illegal mode for this kind
// -----------------------------------------------------------------------------
module mem_stage_lsu_align
  import mem_stage_lsu_pkg::*;
(
  input  logic            i_is_load,
  input  logic            i_is_store,
  input  logic [2:0]      i_mode,
  input  logic [1:0]      i_addr_lo,
  input  logic [XLEN-1:0] i_store_data,
  input  logic [XLEN-1:0] i_rdata,
  output logic [3:0]      o_be,
  output logic [XLEN-1:0] o_wdata,
  output logic [XLEN-1:0] o_load_data,
  output logic            o_fault
);

  function automatic logic [XLEN-1:0] sext8(input logic [7:0] b);
    return {{(XLEN-8){b[7]}}, b};
  endfunction

  function automatic logic [XLEN-1:0] sext16(input logic [15:0] h);
    return {{(XLEN-16){h[15]}}, h};
  endfunction

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_misaligned;
  logic        w_bad_load_mode;
  logic        w_bad_store_mode;

  // Size comes from mode[1:0]; the unsigned variants only differ in mode[2].
  assign w_misaligned     = ((i_mode[1:0] == 2'b01) & i_addr_lo[0]) |
                            ((i_mode[1:0] == 2'b10) & (|i_addr_lo));
  assign w_bad_load_mode  = (i_mode == 3'b011) | (i_mode[2:1] == 2'b11);
  assign w_bad_store_mode = (i_mode > 3'b010);
  assign o_fault          = (i_is_load  & (w_bad_load_mode  | w_misaligned)) |
                            (i_is_store & (w_bad_store_mode | w_misaligned));

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_store_data;
    case (i_mode[1:0])
      2'b00: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_store_data[7:0]}};
      end
      2'b01: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_store_data[15:0]}};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_store_data;
      end
    endcase
  end

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_load_data = i_rdata;
    case (i_mode)
      MODE_B:  o_load_data = sext8(w_byte);
      MODE_BU: o_load_data = {{(XLEN-8){1'b0}}, w_byte};
      MODE_H:  o_load_data = sext16(w_half);
      MODE_HU: o_load_data = {{(XLEN-16){1'b0}}, w_half};
      default: o_load_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
//   MEM pipeline stage: EX/MEM register, data-memory req/ack handshake with an
//   optional ack watchdog, writeback select and MEM/WB register.
//   Ports:
//     clk, rst                 : clock, synchronous active-high reset
//     i_Valid, i_ctrl_Busy     : EX instruction valid / EX busy (capture bubble)
//     i_ALU_Result ... i_Rd    : EX results, effective address, store data
//     i_ctrl_*                 : decoded control of the EX instruction
//     o_dmem_* / i_dmem_*      : data-memory request/ack port
//     o_MEM_WriteData, o_MEM_Rd, o_ctrl_MEM_RegWrite : forwarding from MEM
//     o_ctrl_Stall             : hold IF..EX while an access is outstanding
//     o_WB_*, o_ctrl_WB_RegWrite : MEM/WB register
//     o_ctrl_Mem_Err           : one-cycle pulse on misalign/illegal/timeout
// -----------------------------------------------------------------------------
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_Valid,
  input  logic                  i_ctrl_Busy,
  input  logic [DATA_WIDTH-1:0] i_ALU_Result,
  input  logic [DATA_WIDTH-1:0] i_Mem_WriteData,
  input  logic [DATA_WIDTH-1:0] i_nPC,
  input  logic [DATA_WIDTH-1:0] i_Imme,
  input  logic [4:0]            i_Rd,
  input  logic                  i_ctrl_MemRead,
  input  logic                  i_ctrl_MemWrite,
  input  logic                  i_ctrl_RegWrite,
  input  logic                  i_ctrl_LUI,
  input  logic                  i_ctrl_Jump,
  input  logic [2:0]            i_ctrl_Mem_Mode,
  output logic                  o_dmem_req,
  output logic                  o_dmem_we,
  output logic [DATA_WIDTH-1:0] o_dmem_addr,
  output logic [DATA_WIDTH-1:0] o_dmem_wdata,
  output logic [3:0]            o_dmem_be,
  input  logic                  i_dmem_ack,
  input  logic [DATA_WIDTH-1:0] i_dmem_rdata,
  output logic [DATA_WIDTH-1:0] o_MEM_WriteData,
  output logic [4:0]            o_MEM_Rd,
  output logic                  o_ctrl_MEM_RegWrite,
  output logic                  o_ctrl_Stall,
  output logic [DATA_WIDTH-1:0] o_WB_WriteData,
  output logic [4:0]            o_WB_Rd,
  output logic                  o_ctrl_WB_RegWrite,
  output logic                  o_ctrl_Mem_Err
);

  // The counter only has to reach ACK_TIMEOUT-1 before the watchdog fires.
  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam bit TIMEOUT_EN = (ACK_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  // ---- EX/MEM register (p0) ----
  logic                  r_vld_p0;
  ex_ctrl_t              r_ctrl_p0;
  logic [DATA_WIDTH-1:0] r_alu_p0;
  logic [DATA_WIDTH-1:0] r_st_data_p0;
  logic [DATA_WIDTH-1:0] r_npc_p0;
  logic [DATA_WIDTH-1:0] r_imme_p0;
  logic [4:0]            r_rd_p0;

  lsu_state_e            r_state;
  lsu_state_e            w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;

  logic                  w_mem_op;
  logic                  w_is_load;
  logic                  w_fault;
  logic                  w_access;
  logic                  w_timeout;
  logic                  w_done;
  logic                  w_err;
  logic                  w_retire_we;
  logic [DATA_WIDTH-1:0] w_result;
  logic [DATA_WIDTH-1:0] w_load_data;

  // ---- MEM/WB register (p1) ----
  logic                  r_wb_we_p1;
  logic [DATA_WIDTH-1:0] r_wb_data_p1;
  logic [4:0]            r_wb_rd_p1;
  logic                  r_mem_err_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p0  <= 1'b0;
      r_ctrl_p0 <= '0;
    end else if (!o_ctrl_Stall) begin
      r_vld_p0  <= i_Valid & ~i_ctrl_Busy;
      r_ctrl_p0 <= '{mem_read:  i_ctrl_MemRead,
                     mem_write: i_ctrl_MemWrite,
                     reg_write: i_ctrl_RegWrite,
                     lui:       i_ctrl_LUI,
                     jump:      i_ctrl_Jump,
                     mode:      i_ctrl_Mem_Mode};
    end
  end

  always_ff @(posedge clk) begin
    if (!o_ctrl_Stall) begin
      r_alu_p0     <= i_ALU_Result;
      r_st_data_p0 <= i_Mem_WriteData;
      r_npc_p0     <= i_nPC;
      r_imme_p0    <= i_Imme;
      r_rd_p0      <= i_Rd;
    end
  end

  // ---- MEM stage: access control and alignment ----
  // A set MemWrite wins over MemRead, so the bus and the alignment unit
  // always agree on the direction of the access.
  assign w_mem_op  = r_vld_p0 & (r_ctrl_p0.mem_read | r_ctrl_p0.mem_write);
  assign w_is_load = r_ctrl_p0.mem_read & ~r_ctrl_p0.mem_write;

  mem_stage_lsu_align u_align (
    .i_is_load    (w_is_load),
    .i_is_store   (r_ctrl_p0.mem_write),
    .i_mode       (r_ctrl_p0.mode),
    .i_addr_lo    (r_alu_p0[1:0]),
    .i_store_data (r_st_data_p0),
    .i_rdata      (i_dmem_rdata),
    .o_be         (o_dmem_be),
    .o_wdata      (o_dmem_wdata),
    .o_load_data  (w_load_data),
    .o_fault      (w_fault)
  );

  // Faulting accesses never reach the bus; r_cnt is zero in S_IDLE, so the
  // same compare covers a timeout on the very first request cycle.
  assign w_access  = w_mem_op & ~w_fault;
  assign w_timeout = TIMEOUT_EN & w_access & ~i_dmem_ack & (r_cnt == CNT_LAST);
  assign w_done    = w_access & i_dmem_ack;

  assign o_dmem_we   = r_ctrl_p0.mem_write;
  assign o_dmem_addr = word_addr(r_alu_p0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = '0;
    o_dmem_req   = 1'b0;
    o_ctrl_Stall = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_dmem_req = w_access;
        if (w_access && !i_dmem_ack && !w_timeout) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      S_WAIT: begin
        o_dmem_req = w_access;
        if (!w_access || i_dmem_ack || w_timeout) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    o_ctrl_Stall = w_access & ~i_dmem_ack & ~w_timeout;
  end

  // Forwarding never exposes a load from MEM: its data is not back yet.
  assign w_result = r_ctrl_p0.jump ? r_npc_p0 :
                    r_ctrl_p0.lui  ? r_imme_p0 : r_alu_p0;

  assign o_MEM_WriteData     = w_result;
  assign o_MEM_Rd            = r_rd_p0;
  assign o_ctrl_MEM_RegWrite = r_vld_p0 & r_ctrl_p0.reg_write & ~r_ctrl_p0.mem_read;

  // A memory op only writes back once acked; stalls and faults retire bubbles.
  assign w_retire_we = r_vld_p0 & r_ctrl_p0.reg_write & (w_mem_op ? w_done : 1'b1);
  assign w_err       = (w_mem_op & w_fault) | w_timeout;

  // ---- MEM/WB register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_we_p1   <= 1'b0;
      r_wb_data_p1 <= '0;
      r_wb_rd_p1   <= '0;
      r_mem_err_p1 <= 1'b0;
    end else begin
      r_wb_we_p1   <= w_retire_we;
      r_wb_data_p1 <= w_is_load ? w_load_data : w_result;
      r_wb_rd_p1   <= r_rd_p0;
      r_mem_err_p1 <= w_err;
    end
  end

  assign o_WB_WriteData     = r_wb_data_p1;
  assign o_WB_Rd            = r_wb_rd_p1;
  assign o_ctrl_WB_RegWrite = r_wb_we_p1;
  assign o_ctrl_Mem_Err     = r_mem_err_p1;

endmodule
